// File: rtl/auc_pkg.sv
// Shared definitions for the auc_mmul host loader: FSM state encoding,
// host header field layout and the words-per-operand derivation.
package auc_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_WRITE,
        S_START,
        S_WAIT,
        S_RD,
        S_CAP,
        S_SEND
    } ldr_state_e;

    localparam int HOST_W       = 32;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LAST_BIT = 31;

    function automatic int calc_nw(input int wid);
        return (wid + HOST_W - 1) / HOST_W;
    endfunction

endpackage

// File: rtl/auc_ldr_ser.sv
// NW x 32-bit shift register shared by operand assembly (words enter at the top,
// so the first word ends up least significant) and result serialization (LSW out).
module auc_ldr_ser
    import auc_pkg::*;
#(
    parameter int NW  = 6,
    parameter int WID = 163
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift_in,
    input  logic [HOST_W-1:0]      din,
    input  logic                   shift_out,
    input  logic                   load,
    input  logic [WID-1:0]         par_in,
    output logic [NW*HOST_W-1:0]   dout
);

    localparam int SW = NW * HOST_W;

    logic [SW-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d            = '0;
            sr_d[WID-1:0]   = par_in;
        end else if (shift_in) begin
            sr_d = {din, sr_q[SW-1:HOST_W]};
        end else if (shift_out) begin
            sr_d = {{HOST_W{1'b0}}, sr_q[SW-1:HOST_W]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q;

endmodule

// File: rtl/auc_mmul_ldr.sv
// Host operand loader / result unloader for auc_mmul. Optional WAIT-state
// watchdog is compiled in when AUC_LDR_WDOG_EN is defined.
module auc_mmul_ldr
    import auc_pkg::*;
#(
    parameter int WID      = 163,
    parameter int AW       = 4,
    parameter int ADDR_RES = 15,
    parameter int TMO      = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [31:0]     in_dat,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [31:0]     out_dat,
    output logic            mmul_en,
    input  logic            mmul_done,
    output logic            ram_own,
    output logic            ram_we,
    output logic [AW-1:0]   ram_wa,
    output logic [WID-1:0]  ram_wd,
    output logic [AW-1:0]   ram_ra,
    input  logic [WID-1:0]  ram_rd,
    output logic            busy,
    output logic            err
);

    localparam int NW = calc_nw(WID);
    localparam int CW = $clog2(NW + 1);

    ldr_state_e         state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               live_q, live_d;

    logic               ser_shin, ser_shout, ser_load;
    logic [NW*32-1:0]   ser_dout;
    logic               unused_ser;

`ifdef AUC_LDR_WDOG_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0]      wd_q, wd_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    localparam int unused_tmo = TMO;
`endif

    auc_ldr_ser #(.NW(NW), .WID(WID)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .shift_in  (ser_shin),
        .din       (in_dat),
        .shift_out (ser_shout),
        .load      (ser_load),
        .par_in    (ram_rd),
        .dout      (ser_dout)
    );

    // Bits above WID only exist to pad the register to whole host words.
    assign unused_ser = ^ser_dout;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        err_d     = err_q;
        live_d    = 1'b1;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        out_dat   = '0;
        mmul_en   = 1'b0;
        ram_own   = 1'b1;
        ram_we    = 1'b0;
        ram_wa    = '0;
        ram_wd    = '0;
        ram_ra    = '0;
        ser_shin  = 1'b0;
        ser_shout = 1'b0;
        ser_load  = 1'b0;
`ifdef AUC_LDR_WDOG_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            S_HDR: begin
                // live_q keeps in_rdy low until the first clock after reset release
                in_rdy = live_q;
                if (in_vld && live_q) begin
                    addr_d  = in_dat[HDR_ADDR_LSB +: AW];
                    last_d  = in_dat[HDR_LAST_BIT];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    ser_shin = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(NW - 1)) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                ram_we  = 1'b1;
                ram_wa  = addr_q;
                ram_wd  = ser_dout[WID-1:0];
                state_d = last_q ? S_START : S_HDR;
            end
            S_START: begin
                mmul_en = 1'b1;
                ram_own = 1'b0;
`ifdef AUC_LDR_WDOG_EN
                wd_d    = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                ram_own = 1'b0;
                if (mmul_done) begin
                    state_d = S_RD;
`ifdef AUC_LDR_WDOG_EN
                end else if (wd_q == TW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_HDR;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            S_RD: begin
                ram_ra  = AW'(ADDR_RES);
                state_d = S_CAP;
            end
            S_CAP: begin
                ser_load = 1'b1;
                cnt_d    = '0;
                state_d  = S_SEND;
            end
            S_SEND: begin
                out_vld = 1'b1;
                out_dat = ser_dout[31:0];
                if (out_rdy) begin
                    ser_shout = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CW'(NW - 1)) begin
                        busy_d  = 1'b0;
                        state_d = S_HDR;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR;
            addr_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_auc_mmul_ldr.sv
// Randomized self-checking bench for auc_mmul_ldr with a frame/word-level scoreboard
// and a behavioural RAM + multiplier model.
module tb_auc_mmul_ldr;

    localparam int WID      = 163;
    localparam int AW       = 4;
    localparam int ADDR_RES = 15;
    localparam int NW       = (WID + 31) / 32;
`ifdef AUC_LDR_WDOG_EN
    localparam int TMO      = 100;
`else
    localparam int TMO      = 65535;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_vld = 1'b0;
    logic            in_rdy;
    logic [31:0]     in_dat = '0;
    logic            out_vld;
    logic            out_rdy = 1'b0;
    logic [31:0]     out_dat;
    logic            mmul_en;
    logic            mmul_done = 1'b0;
    logic            ram_own, ram_we;
    logic [AW-1:0]   ram_wa, ram_ra;
    logic [WID-1:0]  ram_wd;
    logic [WID-1:0]  ram_rd = '0;
    logic            busy, err;

    auc_mmul_ldr #(.WID(WID), .AW(AW), .ADDR_RES(ADDR_RES), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
        .mmul_en(mmul_en), .mmul_done(mmul_done),
        .ram_own(ram_own), .ram_we(ram_we), .ram_wa(ram_wa), .ram_wd(ram_wd),
        .ram_ra(ram_ra), .ram_rd(ram_rd),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with one registered read port; the multiplier model writes only when it owns the port.
    logic [WID-1:0] mem [16];
    logic           mul_we = 1'b0;
    logic [WID-1:0] mul_wd = '0;
    always @(posedge clk) begin
        if (ram_own && ram_we) mem[ram_wa] <= ram_wd;
        if (!ram_own && mul_we) mem[ADDR_RES] <= mul_wd;
        ram_rd <= mem[ram_ra];
    end

    task automatic chk(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [AW-1:0]  exp_wa [$];
    logic [WID-1:0] exp_wd [$];
    logic           exp_last [$];
    logic [31:0]    exp_out [$];
    logic [31:0]    got_out [$];
    int             last_we_cyc = -10;
    logic           last_we_flag = 1'b0;
    logic [AW-1:0]  lit_wa = '0;
    logic [WID-1:0] lit_wd = '0;
    int             en_count = 0;
    int             we_count = 0;
    int             done_cyc = 0;
    logic           first_pending = 1'b0;
    logic           held_valid = 1'b0;
    logic [31:0]    held_dat = '0;
    logic           busy_check = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            held_valid = 1'b0;
        end else begin
            if (busy_check) begin
                chk("busy_fall", busy, 0);
                busy_check = 1'b0;
            end
            if (held_valid) begin
                chk("vld_hold", out_vld, 1);
                chk("dat_hold", out_dat, held_dat);
            end
            if (ram_we) begin
                we_count++;
                chk("we_own", ram_own, 1);
                if (exp_wa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: addr %0d data %0h", ram_wa, ram_wd);
                    last_we_flag = 1'b0;
                end else begin
                    chk("wa", ram_wa, exp_wa.pop_front());
                    chk("wd", ram_wd, exp_wd.pop_front());
                    last_we_flag = exp_last.pop_front();
                end
                last_we_cyc = cyc;
                lit_wa = ram_wa;
                lit_wd = ram_wd;
            end
            if (mmul_en) begin
                en_count++;
                chk("en_own", ram_own, 0);
                chk("en_after_last_write", (last_we_flag && last_we_cyc == cyc - 1), 1);
            end
            if (out_vld) begin
                chk("in_rdy_in_send", in_rdy, 0);
                chk("busy_in_send", busy, 1);
                if (first_pending) begin
                    chk("done_to_vld", cyc - done_cyc, 3);
                    first_pending = 1'b0;
                end
                if (out_rdy) begin
                    if (exp_out.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out: got %0h with nothing expected", out_dat);
                    end else begin
                        chk("out_dat", out_dat, exp_out.pop_front());
                        got_out.push_back(out_dat);
                        if (exp_out.size() == 0) busy_check = 1'b1;
                    end
                end
                held_valid = !out_rdy;
                held_dat   = out_dat;
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    function automatic logic [WID-1:0] rand_op();
        logic [NW*32-1:0] f;
        for (int i = 0; i < NW; i++) f[32*i +: 32] = $urandom;
        return f[WID-1:0];
    endfunction

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        if ($urandom_range(0, 3) == 0) begin
            in_vld = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        in_vld = 1'b1;
        in_dat = w;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            n++;
            if (n > 400) begin
                total++; bad++;
                $display("FAIL in_accept_timeout: in_rdy low for %0d cycles", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic send_frame(input logic [AW-1:0] addr, input logic last,
                              input logic [WID-1:0] op, input logic garb);
        logic [31:0]      hdr;
        logic [NW*32-1:0] full;
        hdr = garb ? 32'($urandom) : 32'h0;
        hdr[AW-1:0] = addr;
        hdr[31]     = last;
        full = '0;
        if (garb) for (int i = 0; i < NW; i++) full[32*i +: 32] = $urandom;
        full[WID-1:0] = op;
        send_word(hdr);
        for (int i = 0; i < NW - 1; i++) send_word(full[32*i +: 32]);
        exp_wa.push_back(addr);
        exp_wd.push_back(op);
        exp_last.push_back(last);
        send_word(full[32*(NW-1) +: 32]);
    endtask

    task automatic wait_en(output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            if (mmul_en) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL en_timeout: no mmul_en within %0d cycles", n);
        end
    endtask

    // Called at the negedge of the mmul_en cycle; done is raised d cycles later.
    task automatic run_mul(input logic [WID-1:0] res, input int d);
        logic [NW*32-1:0] full;
        repeat (d - 1) @(posedge clk);
        #1;
        mul_we = 1'b1;
        mul_wd = res;
        @(posedge clk);
        #1;
        mul_we        = 1'b0;
        mmul_done     = 1'b1;
        done_cyc      = cyc;
        first_pending = 1'b1;
        full = '0;
        full[WID-1:0] = res;
        for (int i = 0; i < NW; i++) exp_out.push_back(full[32*i +: 32]);
        @(posedge clk);
        #1;
        mmul_done = 1'b0;
    endtask

    task automatic recv(input int mode);
        int n;
        n = 0;
        while (exp_out.size() != 0 || busy_check) begin
            @(posedge clk);
            #1;
            if (mode == 1) out_rdy = (n % 4 == 0) || (n % 4 == 3);
            else           out_rdy = 1'($urandom_range(0, 1));
            n++;
            if (n > 400) begin
                total++; bad++;
                $display("FAIL recv_timeout: %0d words outstanding", exp_out.size());
                break;
            end
        end
        out_rdy = 1'b0;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_in_rdy"},  in_rdy,  0);
        chk({p, "_out_vld"}, out_vld, 0);
        chk({p, "_out_dat"}, out_dat, 0);
        chk({p, "_mmul_en"}, mmul_en, 0);
        chk({p, "_ram_own"}, ram_own, 1);
        chk({p, "_ram_we"},  ram_we,  0);
        chk({p, "_ram_wa"},  ram_wa,  0);
        chk({p, "_ram_wd"},  ram_wd,  0);
        chk({p, "_ram_ra"},  ram_ra,  0);
        chk({p, "_busy"},    busy,    0);
        chk({p, "_err"},     err,     0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok;
        int   en_base;
        int   we_base;
        int   nops;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("in_rdy_pre", in_rdy, 0);
        @(negedge clk);
        chk("in_rdy_rise", in_rdy, 1);
        @(posedge clk);
        #1;

        // Single operand k=5 at address 11 with the last flag.
        send_frame(4'd11, 1'b1, WID'(5), 1'b0);
        wait_en(ok);
        chk("A_wa", lit_wa, 11);
        chk("A_wd", lit_wd, 5);
        chk("A_own", ram_own, 0);
        chk("A_busy", busy, 1);
        run_mul(WID'(32'h1234), 40);
        got_out.delete();
        recv(0);
        chk("A_nwords", got_out.size(), 6);
        chk("A_w0", got_out[0], 32'h0000_1234);
        for (int i = 1; i < 6; i++) chk("A_wz", got_out[i], 0);

        // Three operands, only the last one starts the multiplier.
        en_base = en_count;
        we_base = we_count;
        send_frame(4'd1, 1'b0, rand_op(), 1'b1);
        send_frame(4'd2, 1'b0, rand_op(), 1'b1);
        send_frame(4'd11, 1'b1, rand_op(), 1'b1);
        wait_en(ok);
        chk("B_we_count", we_count - we_base, 3);
        run_mul(rand_op(), 2 + $urandom_range(0, 20));
        fork
            recv(1);
            begin
                repeat (2) @(posedge clk);
                #1;
                send_frame(4'd7, 1'b0, rand_op(), 1'b1);
            end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("B_en_count", en_count - en_base, 1);

        // Stray done while idle must be ignored.
        mmul_done = 1'b1;
        @(posedge clk);
        #1 mmul_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("C_no_vld", out_vld, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of DATA discards the partial operand.
        send_word(32'h8000_0003);
        for (int i = 0; i < 3; i++) send_word($urandom);
        #2 rst = 1'b0;
        #1 check_reset("mid");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        send_frame(4'd3, 1'b1, rand_op(), 1'b1);
        wait_en(ok);
        run_mul(rand_op(), $urandom_range(2, 30));
        recv(0);

        for (int j = 0; j < 12; j++) begin
            nops = $urandom_range(1, 3);
            if ($urandom_range(0, 2) == 0) begin
                mmul_done = 1'b1;
                @(posedge clk);
                #1 mmul_done = 1'b0;
            end
            for (int k = 0; k < nops; k++)
                send_frame(4'($urandom_range(0, 15)), (k == nops - 1), rand_op(), 1'b1);
            wait_en(ok);
            run_mul(rand_op(), $urandom_range(2, 60));
            recv($urandom_range(0, 1));
        end

`ifdef AUC_LDR_WDOG_EN
        send_frame(4'd5, 1'b1, rand_op(), 1'b1);
        wait_en(ok);
        repeat (TMO) @(negedge clk);
        chk("W_err_before", err, 0);
        chk("W_own_before", ram_own, 0);
        @(negedge clk);
        chk("W_err", err, 1);
        chk("W_own", ram_own, 1);
        chk("W_busy", busy, 0);
        @(posedge clk);
        #1;
        send_frame(4'd6, 1'b0, rand_op(), 1'b1);
        @(negedge clk);
        chk("W_err_clr", err, 0);
`endif

        repeat (5) @(posedge clk);
        chk("wr_queue_empty", exp_wa.size(), 0);
        chk("out_queue_empty", exp_out.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
